// File: rtl/tag_pkg.sv
// Shared types, default widths and the word-to-tag XOR fold
// used by the tag verifier and its accumulator.
package tag_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ABSORB,
      WAIT_TAG,
      RESULT
   } state_t;

   localparam int DEF_KEY_WIDTH  = 256;
   localparam int DEF_TAG_WIDTH  = 8;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MAX_WORDS  = 16;

   // Widest word the fold accepts.
   localparam int FOLD_MAX = 256;

   // XOR of all tw-bit chunks of the low dw bits of d.
   // Result sits in the low tw bits; the caller keeps only those.
   function automatic logic [FOLD_MAX-1:0] fold(
      input logic [FOLD_MAX-1:0] d,
      input int dw,
      input int tw
   );
      logic [FOLD_MAX-1:0] r;
      r = '0;
      for (int c = 0; c * tw < dw; c++)
         r = r ^ (d >> (c * tw));
      return r;
   endfunction

endpackage

// File: rtl/tag_verifier_if.sv
// Control, message-word and tag handshake bundle of tag_verifier.
// master: requester side (start, words, tag); slave: the verifier.
interface tag_verifier_if
   import tag_pkg::*;
#(
   parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
   parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

   logic                  start;
   logic [KEY_WIDTH-1:0]  key_in;
   logic [TAG_WIDTH-1:0]  tag_mask;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  tag_valid;
   logic [TAG_WIDTH-1:0]  tag_in;
   logic                  busy;
   logic                  done;
   logic                  auth_ok;
   logic                  overflow;

   modport master (
      output start, key_in, tag_mask,
      output in_valid, in_data, in_last,
      output tag_valid, tag_in,
      input  in_ready, busy, done, auth_ok, overflow
   );

   modport slave (
      input  start, key_in, tag_mask,
      input  in_valid, in_data, in_last,
      input  tag_valid, tag_in,
      output in_ready, busy, done, auth_ok, overflow
   );

endinterface

// File: rtl/tag_accumulator.sv
// Tag accumulator: selects the key slice for the current word,
// masks and folds the word, and rotates it into acc.
// Ports: clk, reset, clear, en, key, data, word_cnt -> acc.
module tag_accumulator
   import tag_pkg::*;
#(
   parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
   parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_W      = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  en,
   input  logic [KEY_WIDTH-1:0]  key,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [CNT_W-1:0]      word_cnt,
   output logic [TAG_WIDTH-1:0]  acc
);

   localparam int NSLICE = KEY_WIDTH / DATA_WIDTH;
   localparam int SEL_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   logic [DATA_WIDTH-1:0] slices [NSLICE];
   logic [SEL_W-1:0]      sel;
   logic [DATA_WIDTH-1:0] m;
   logic [FOLD_MAX-1:0]   fw;
   logic [TAG_WIDTH-1:0]  f;
   logic [TAG_WIDTH-1:0]  rot;
   logic                  fold_unused;

   for (genvar g = 0; g < NSLICE; g++) begin : g_slice
      assign slices[g] = key[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // The key repeats every NSLICE words.
   assign sel = SEL_W'(int'(word_cnt) % NSLICE);
   assign m   = data ^ slices[sel];
   assign fw  = fold(FOLD_MAX'(m), DATA_WIDTH, TAG_WIDTH);
   assign f   = fw[TAG_WIDTH-1:0];
   assign rot = {acc[TAG_WIDTH-2:0], acc[TAG_WIDTH-1]};

   assign fold_unused = ^fw[FOLD_MAX-1:TAG_WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         acc <= '0;
      else if (clear)
         acc <= '0;
      else if (en)
         acc <= rot ^ f;
   end

endmodule

// File: rtl/tag_verifier.sv
// Keyed message authenticator: absorbs up to MAX_WORDS words,
// then compares the masked accumulator against a received tag.
// Ports: clk, reset (async, high), bus (tag_verifier_if.slave).
module tag_verifier
   import tag_pkg::*;
#(
   parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
   parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_WORDS  = DEF_MAX_WORDS
) (
   input logic           clk,
   input logic           reset,
   tag_verifier_if.slave bus
);

   localparam int CNT_W = $clog2(MAX_WORDS + 1);

   state_t               state;
   state_t               next;
   logic [KEY_WIDTH-1:0] key_q;
   logic [TAG_WIDTH-1:0] mask_q;
   logic [TAG_WIDTH-1:0] acc;
   logic [CNT_W-1:0]     word_cnt;
   logic                 go;
   logic                 accept;
   logic                 final_slot;
   logic                 tag_hit;

   assign go         = (state == IDLE) && bus.start;
   assign accept     = (state == ABSORB) && bus.in_valid;
   assign final_slot = (word_cnt == CNT_W'(MAX_WORDS - 1));
   assign tag_hit    = (state == WAIT_TAG) && bus.tag_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         IDLE:
            if (bus.start)
               next = ABSORB;
         ABSORB:
            if (bus.in_valid) begin
               if (bus.in_last)
                  next = WAIT_TAG;
               else if (final_slot)
                  next = RESULT;
            end
         WAIT_TAG:
            if (bus.tag_valid)
               next = RESULT;
         RESULT:
            next = IDLE;
         default:
            next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = (state == ABSORB);
      bus.busy     = (state != IDLE);
      bus.done     = (state == RESULT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_q        <= '0;
         mask_q       <= '0;
         word_cnt     <= '0;
         bus.auth_ok  <= 1'b0;
         bus.overflow <= 1'b0;
      end else if (go) begin
         key_q        <= bus.key_in;
         mask_q       <= bus.tag_mask;
         word_cnt     <= '0;
         bus.auth_ok  <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         if (accept) begin
            word_cnt <= word_cnt + 1'b1;
            if (!bus.in_last && final_slot)
               bus.overflow <= 1'b1;
         end
         if (tag_hit)
            bus.auth_ok <= ((acc ^ mask_q) == bus.tag_in);
      end
   end

   tag_accumulator #(
      .KEY_WIDTH  (KEY_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_W      (CNT_W)
   ) u_acc (
      .clk      (clk),
      .reset    (reset),
      .clear    (go),
      .en       (accept),
      .key      (key_q),
      .data     (bus.in_data),
      .word_cnt (word_cnt),
      .acc      (acc)
   );

endmodule
